transconv_tile_scheduler: RTL and testbench
===========================================

# transconv_tile_scheduler

Tile-level controller for the transpose-convolution input path. It splits a layer's temporal length into tiles of `Dimension` output positions. For each tile it launches `input_microsequencer` (an `en` pulse the first time after reset, a `restart` pulse afterwards) and waits for that tile's `done`. It holds the next launch until the downstream drain stage is ready, and reports progress and completion to the top-level FSM. It also latches the layer configuration and drives it as stable inputs to the microsequencer for the whole layer.

## Interface
- `Dimension`, 16: outputs per tile. Must be a power of two.
- `TIMEOUT`, 4095: maximum cycles allowed from a launch to `seq_done` before the block errors.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled in IDLE only; begins a layer.
- `abort`  in  1  stops scheduling after the current tile completes.
- `stride`  in  2  raw stride. 0 is treated as 1.
- `padding`  in  3  layer padding.
- `kernel_size`  in  5  layer kernel size.
- `temporal_length`  in  10  input length.
- `drain_ready`  in  1  downstream can accept a new tile.
- `seq_done`  in  1  microsequencer done level.
- `seq_en`  out  1  one-cycle pulse; first launch after reset.
- `seq_restart`  out  1  one-cycle pulse; every later launch.
- `cfg_stride`  out  2  latched `stride`.
- `cfg_padding`  out  3  latched `padding`.
- `cfg_kernel_size`  out  5  latched `kernel_size`.
- `cfg_temporal_length`  out  10  latched `temporal_length`.
- `tile_idx`  out  7  current tile number.
- `tile_base_addr`  out  12  ifmap base address of the current tile.
- `tile_done`  out  1  one-cycle pulse per finished tile.
- `busy`  out  1  high in every state except IDLE.
- `all_done`  out  1  one-cycle pulse at end of layer.
- `err`  out  1  sticky watchdog error.

## Operation
Derived quantities:
- `stride_val` = (`cfg_stride`==0) ? 1 : `cfg_stride`.
- `n_tiles` = ceil(`cfg_temporal_length` / `Dimension`), computed as (len + `Dimension`−1) >> log2(`Dimension`). It is 7 bits and registered in SETUP.
- `tile_base_addr` = `tile_idx` × `Dimension` × `stride_val`. Zero-extended, 12 bits, no overflow for legal inputs.
- `primed` is an internal flag. It is set on the first `seq_en` and cleared only by `rst`. It selects `seq_en` (primed=0) or `seq_restart` (primed=1).

State machine:
- IDLE: on `start`=1, latch all `cfg_*` → SETUP.
- SETUP: register `n_tiles`; clear `tile_idx` to 0. If `n_tiles`==0 → FINISH, else → LAUNCH.
- LAUNCH: wait for `drain_ready`=1. When it is high, pulse `seq_en` or `seq_restart` for one cycle, clear the watchdog → ARM.
- ARM: wait for `seq_done`=0. This ignores the stale done level held by the microsequencer between restart and its INIT state. Then → RUN.
- RUN: wait for `seq_done`=1 → TILE_END.
- TILE_END: pulse `tile_done`.
  - If `abort` was seen during the tile → IDLE.
  - Else if `tile_idx`==`n_tiles`−1 → FINISH.
  - Else increment `tile_idx` → LAUNCH.
- FINISH: pulse `all_done` → IDLE.
- ERR: `err`=1, all pulse outputs held at 0. Exits only on `rst`.

Watchdog and abort:
- The watchdog counts in ARM and RUN. If the count reaches `TIMEOUT` → ERR.
- `abort` is captured into a sticky flag in any busy state and cleared on entering IDLE.
- Abort in LAUNCH before a pulse has issued → IDLE immediately, with no pulse.
- Abort in ARM or RUN is honoured at TILE_END; the tile runs to completion.
- After an abort, the next `start` uses `seq_restart`, because `primed` remains 1.

## Timing
- Reset values:
  - All outputs 0, including `cfg_*`, `tile_idx`, `tile_base_addr` and `err`.
  - State IDLE, `primed`=0.
- Latency from `start` (seen in IDLE at cycle 0) to the first launch pulse is cycle 2, provided `drain_ready`=1.
- From `seq_done` rising to `tile_done` is 1 cycle. From `tile_done` to the next launch pulse is at least 1 cycle.
- `cfg_*` and `tile_base_addr` are stable from SETUP until IDLE is re-entered; `tile_base_addr` changes only in TILE_END.
- `start` asserted while busy is ignored.
- `abort` and the last tile in the same cycle: abort takes priority, so → IDLE and `all_done` is not pulsed.
- `rst` mid-layer returns the block to IDLE asynchronously. The microsequencer shares `rst`, so `primed`=0 is consistent with its state.

## Test plan
- `temporal_length`=48, stride=1, `drain_ready`=1 → one `seq_en` then two `seq_restart`; `tile_base_addr` 0, 16, 32; three `tile_done` pulses; one `all_done`.
- Second layer with stride=2, `temporal_length`=40 → 3 tiles; only `seq_restart` pulses are used; bases 0, 32, 64.
- `drain_ready` held low for 20 cycles after tile 0 → no launch pulse during those cycles; the launch pulse follows 1 cycle after `drain_ready` rises; `busy` stays 1.
- `seq_done` never rises, `TIMEOUT`=100 → `err`=1 at launch+101 cycles, no further pulses; `rst` clears `err`.
- `abort` asserted during RUN of tile 1 of 4 → `tile_done` for tile 1, then IDLE, `all_done` never asserted; the next `start` launches with `seq_restart`.
- `temporal_length`=0 → `all_done` at cycle 2 after `start`, no `seq_en` or `seq_restart`.

Source files
------------

// File: rtl/transconv_tile_scheduler.sv
// Tile scheduler for the transpose-convolution input path: splits a layer into
// Dimension-wide tiles, launches the microsequencer per tile and reports progress.
module transconv_tile_scheduler #(
    parameter int Dimension = 16,
    parameter int TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  stride,
    input  logic [2:0]  padding,
    input  logic [4:0]  kernel_size,
    input  logic [9:0]  temporal_length,
    input  logic        drain_ready,
    input  logic        seq_done,
    output logic        seq_en,
    output logic        seq_restart,
    output logic [1:0]  cfg_stride,
    output logic [2:0]  cfg_padding,
    output logic [4:0]  cfg_kernel_size,
    output logic [9:0]  cfg_temporal_length,
    output logic [6:0]  tile_idx,
    output logic [11:0] tile_base_addr,
    output logic        tile_done,
    output logic        busy,
    output logic        all_done,
    output logic        err
);

    localparam int SHIFT = $clog2(Dimension);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LAUNCH,
        ARM,
        RUN,
        TILE_END,
        FINISH,
        ERR
    } state_t;

    state_t          state;
    logic            primed;
    logic            abort_seen;
    logic [6:0]      n_tiles;
    logic [WD_W-1:0] wdog;

    logic [1:0]      stride_val;
    logic [10:0]     len_round;
    logic [10:0]     tiles_calc;
    logic [11:0]     tile_step;

    assign stride_val = (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
    assign len_round  = {1'b0, cfg_temporal_length} + 11'(Dimension - 1);
    assign tiles_calc = len_round >> SHIFT;
    // Base address advances by one tile step instead of multiplying tile_idx.
    assign tile_step  = 12'(Dimension) * {10'd0, stride_val};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            primed              <= 1'b0;
            abort_seen          <= 1'b0;
            n_tiles             <= '0;
            wdog                <= '0;
            seq_en              <= 1'b0;
            seq_restart         <= 1'b0;
            cfg_stride          <= '0;
            cfg_padding         <= '0;
            cfg_kernel_size     <= '0;
            cfg_temporal_length <= '0;
            tile_idx            <= '0;
            tile_base_addr      <= '0;
            tile_done           <= 1'b0;
            busy                <= 1'b0;
            all_done            <= 1'b0;
            err                 <= 1'b0;
        end else begin
            seq_en      <= 1'b0;
            seq_restart <= 1'b0;
            tile_done   <= 1'b0;
            all_done    <= 1'b0;

            if (state != IDLE && state != ERR && abort) begin
                abort_seen <= 1'b1;
            end

            case (state)
                IDLE: begin
                    abort_seen <= 1'b0;
                    if (start) begin
                        cfg_stride          <= stride;
                        cfg_padding         <= padding;
                        cfg_kernel_size     <= kernel_size;
                        cfg_temporal_length <= temporal_length;
                        busy                <= 1'b1;
                        state               <= SETUP;
                    end
                end

                SETUP: begin
                    n_tiles        <= 7'(tiles_calc);
                    tile_idx       <= '0;
                    tile_base_addr <= '0;
                    state          <= (tiles_calc == 11'd0) ? FINISH : LAUNCH;
                end

                LAUNCH: begin
                    if (abort || abort_seen) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (drain_ready) begin
                        if (primed) begin
                            seq_restart <= 1'b1;
                        end else begin
                            seq_en <= 1'b1;
                        end
                        primed <= 1'b1;
                        wdog   <= '0;
                        state  <= ARM;
                    end
                end

                // ARM skips the done level left over from the previous tile.
                ARM: begin
                    if (wdog == WD_W'(TIMEOUT)) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                        if (!seq_done) begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (wdog == WD_W'(TIMEOUT)) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                        if (seq_done) begin
                            tile_done <= 1'b1;
                            state     <= TILE_END;
                        end
                    end
                end

                TILE_END: begin
                    if (abort || abort_seen) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tile_idx == n_tiles - 7'd1) begin
                        state <= FINISH;
                    end else begin
                        tile_idx       <= tile_idx + 7'd1;
                        tile_base_addr <= tile_base_addr + tile_step;
                        state          <= LAUNCH;
                    end
                end

                FINISH: begin
                    all_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                ERR: begin
                    err <= 1'b1;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transconv_tile_scheduler.sv
// Scoreboard bench for transconv_tile_scheduler: a layer-level model predicts the
// pulse sequence, a monitor checks every pulse the DUT produces against it.
module tb_transconv_tile_scheduler;

    localparam int DIM = 16;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  stride;
    logic [2:0]  padding;
    logic [4:0]  kernel_size;
    logic [9:0]  temporal_length;
    logic        drain_ready;
    logic        seq_done;
    logic        seq_en;
    logic        seq_restart;
    logic [1:0]  cfg_stride;
    logic [2:0]  cfg_padding;
    logic [4:0]  cfg_kernel_size;
    logic [9:0]  cfg_temporal_length;
    logic [6:0]  tile_idx;
    logic [11:0] tile_base_addr;
    logic        tile_done;
    logic        busy;
    logic        all_done;
    logic        err;

    transconv_tile_scheduler #(.Dimension(DIM), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .stride(stride), .padding(padding), .kernel_size(kernel_size),
        .temporal_length(temporal_length), .drain_ready(drain_ready),
        .seq_done(seq_done), .seq_en(seq_en), .seq_restart(seq_restart),
        .cfg_stride(cfg_stride), .cfg_padding(cfg_padding),
        .cfg_kernel_size(cfg_kernel_size), .cfg_temporal_length(cfg_temporal_length),
        .tile_idx(tile_idx), .tile_base_addr(tile_base_addr), .tile_done(tile_done),
        .busy(busy), .all_done(all_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int idx;
        int base;
        int strd;
        int pad;
        int ks;
        int len;
    } ev_t;

    ev_t exp_q[$];
    int  launch_cyc_q[$];
    int  alldone_cyc_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    bit  model_primed = 1'b0;
    bit  hang_mode = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "seq_en";
            1: return "seq_restart";
            2: return "tile_done";
            default: return "all_done";
        endcase
    endfunction

    task automatic check_val(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_ev(input int kind, input int idx, input int base,
                           input int strd, input int pad, input int ks, input int len);
        ev_t e;
        e.kind = kind; e.idx = idx; e.base = base;
        e.strd = strd; e.pad = pad; e.ks = ks; e.len = len;
        exp_q.push_back(e);
    endtask

    // Layer-level reference: ceil-divide into tiles, one launch and one done per tile.
    task automatic push_layer(input int len, input int strd, input int pad, input int ks,
                              input int abort_tile, input bit launch_only);
        int n;
        int sv;
        n  = (len + DIM - 1) / DIM;
        sv = (strd == 0) ? 1 : strd;
        for (int t = 0; t < n; t++) begin
            push_ev(model_primed ? 1 : 0, t, t * DIM * sv, strd, pad, ks, len);
            model_primed = 1'b1;
            if (launch_only) return;
            push_ev(2, t, t * DIM * sv, strd, pad, ks, len);
            if (t == abort_tile) return;
        end
        push_ev(3, -1, 0, strd, pad, ks, len);
    endtask

    task automatic mon_event(input int kind);
        ev_t e;
        bit  ok;
        if (kind < 2) launch_cyc_q.push_back(cyc);
        if (kind == 3) alldone_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pulse: got %s at cycle %0d, expected no pulse",
                     kname(kind), cyc);
            return;
        end
        e  = exp_q.pop_front();
        ok = (kind == e.kind) && (int'(cfg_stride) == e.strd) && (int'(cfg_padding) == e.pad)
          && (int'(cfg_kernel_size) == e.ks) && (int'(cfg_temporal_length) == e.len)
          && (e.idx < 0 || (int'(tile_idx) == e.idx && int'(tile_base_addr) == e.base));
        if (!ok) begin
            errors++;
            $display("[TB] FAIL event: got %s idx=%0d base=%0d cfg=%0d/%0d/%0d/%0d, expected %s idx=%0d base=%0d cfg=%0d/%0d/%0d/%0d",
                     kname(kind), tile_idx, tile_base_addr, cfg_stride, cfg_padding,
                     cfg_kernel_size, cfg_temporal_length, kname(e.kind), e.idx, e.base,
                     e.strd, e.pad, e.ks, e.len);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (seq_en)      mon_event(0);
            if (seq_restart) mon_event(1);
            if (tile_done)   mon_event(2);
            if (all_done)    mon_event(3);
        end
    end

    // Microsequencer stand-in: stale done for a few cycles, then low, then high.
    initial begin
        seq_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (seq_en || seq_restart)) begin
                if (hang_mode) begin
                    seq_done = 1'b0;
                end else begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    seq_done = 1'b0;
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    seq_done = 1'b1;
                end
            end
        end
    end

    task automatic scramble_inputs();
        stride          = 2'($urandom);
        padding         = 3'($urandom);
        kernel_size     = 5'($urandom);
        temporal_length = 10'($urandom);
    endtask

    task automatic apply_stimulus(input int len, input int strd, input int abort_tile,
                                  input bit launch_only);
        @(negedge clk);
        stride          = 2'(strd);
        temporal_length = 10'(len);
        padding         = 3'($urandom);
        kernel_size     = 5'($urandom);
        start           = 1'b1;
        start_cyc       = cyc + 1;
        push_layer(len, strd, int'(padding), int'(kernel_size), abort_tile, launch_only);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle(input int abort_tile, input bit rand_drain, input bit poke);
        int n;
        bit aborted;
        n = 0;
        aborted = 1'b0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
            abort = 1'b0;
            if (start) start = 1'b0;
            else if (poke && (seq_en || seq_restart) && $urandom_range(0, 1) == 1) start = 1'b1;
            if (!aborted && abort_tile >= 0 && (seq_en || seq_restart)
                && int'(tile_idx) == abort_tile) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (rand_drain) drain_ready = ($urandom_range(0, 3) != 0);
            scramble_inputs();
        end
        abort       = 1'b0;
        start       = 1'b0;
        drain_ready = 1'b1;
        check_val("layer_returns_idle", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_output_reset();
        check_val("rst_seq_en", int'(seq_en), 0);
        check_val("rst_seq_restart", int'(seq_restart), 0);
        check_val("rst_tile_done", int'(tile_done), 0);
        check_val("rst_all_done", int'(all_done), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_tile_idx", int'(tile_idx), 0);
        check_val("rst_tile_base_addr", int'(tile_base_addr), 0);
        check_val("rst_cfg_stride", int'(cfg_stride), 0);
        check_val("rst_cfg_padding", int'(cfg_padding), 0);
        check_val("rst_cfg_kernel_size", int'(cfg_kernel_size), 0);
        check_val("rst_cfg_temporal_length", int'(cfg_temporal_length), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int nl;
        int na;
        int n;
        int launches;
        int busy_low;
        int len;
        int s;
        int nt;
        int at;

        rst = 1'b0; start = 1'b0; abort = 1'b0; drain_ready = 1'b1;
        stride = '0; padding = '0; kernel_size = '0; temporal_length = '0;
        repeat (3) @(negedge clk);
        check_output_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] layer len=48 stride=1");
        nl = launch_cyc_q.size();
        apply_stimulus(48, 1, -1, 1'b0);
        wait_idle(-1, 1'b0, 1'b0);
        if (launch_cyc_q.size() > nl) check_val("first_launch_latency", launch_cyc_q[nl] - start_cyc, 2);
        else check_val("first_launch_seen", launch_cyc_q.size(), nl + 1);

        $display("[TB] layer len=40 stride=2");
        apply_stimulus(40, 2, -1, 1'b0);
        wait_idle(-1, 1'b0, 1'b0);

        $display("[TB] drain_ready held low after tile 0");
        apply_stimulus(64, 1, -1, 1'b0);
        n = 0;
        while (!(tile_done && tile_idx == 7'd0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("tile0_done_seen", int'(tile_done), 1);
        drain_ready = 1'b0;
        launches = 0;
        busy_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (seq_en || seq_restart) launches++;
            if (!busy) busy_low++;
        end
        check_val("no_launch_while_drain_low", launches, 0);
        check_val("busy_while_drain_low", busy_low, 0);
        drain_ready = 1'b1;
        @(negedge clk);
        check_val("launch_after_drain_ready", int'(seq_restart), 1);
        wait_idle(-1, 1'b0, 1'b0);

        $display("[TB] abort during tile 1 of 4, then restart");
        apply_stimulus(64, 1, 1, 1'b0);
        wait_idle(1, 1'b0, 1'b0);
        apply_stimulus(32, 3, -1, 1'b0);
        wait_idle(-1, 1'b0, 1'b0);

        $display("[TB] empty layer");
        nl = launch_cyc_q.size();
        na = alldone_cyc_q.size();
        apply_stimulus(0, 2, -1, 1'b0);
        wait_idle(-1, 1'b0, 1'b0);
        if (alldone_cyc_q.size() > na) check_val("empty_all_done_latency", alldone_cyc_q[na] - start_cyc, 2);
        else check_val("empty_all_done_seen", alldone_cyc_q.size(), na + 1);
        check_val("empty_no_launch", launch_cyc_q.size(), nl);

        $display("[TB] abort while waiting in launch");
        drain_ready = 1'b0;
        @(negedge clk);
        stride = 2'd1; temporal_length = 10'd32; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("launch_abort_idle", int'(busy), 0);
        drain_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] randomized layers");
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(0, 200);
            s   = $urandom_range(0, 3);
            nt  = (len + DIM - 1) / DIM;
            at  = -1;
            if (nt > 0 && $urandom_range(0, 3) == 0) at = $urandom_range(0, nt - 1);
            apply_stimulus(len, s, at, 1'b0);
            wait_idle(at, 1'b1, 1'b1);
        end

        $display("[TB] watchdog timeout");
        check_val("queue_empty_before_timeout", exp_q.size(), 0);
        hang_mode = 1'b1;
        nl = launch_cyc_q.size();
        apply_stimulus(48, 1, -1, 1'b1);
        n = 0;
        while (!err && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("err_raised", int'(err), 1);
        if (launch_cyc_q.size() > nl) check_val("err_latency", cyc - launch_cyc_q[nl], TMO + 1);
        else check_val("timeout_launch_seen", launch_cyc_q.size(), nl + 1);
        repeat (20) @(negedge clk);
        check_val("err_sticky", int'(err), 1);
        check_val("busy_in_err", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_clears_err", int'(err), 0);
        check_val("rst_clears_busy", int'(busy), 0);
        rst = 1'b1;
        model_primed = 1'b0;
        hang_mode = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] layer after reset uses seq_en again");
        apply_stimulus(48, 1, -1, 1'b0);
        wait_idle(-1, 1'b0, 1'b0);

        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
